// File: rtl/mem_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// MemArbType
//   Shared types and constants for the fetch/data memory arbiter.
//   owner_t     : tag carried down the response pipe to say who owns the
//                 read data coming back from memory.
//   arb_state_t : arbiter FSM states.
//   Range constants document the legal parameter envelope of mem_arbiter.
// ----------------------------------------------------------------------------
package MemArbType;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    IF   = 2'd1,
    D    = 2'd2
  } owner_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    TURN  = 2'd2
  } arb_state_t;

  localparam int MIN_LATENCY = 1;
  localparam int MAX_LATENCY = 4;
  localparam int MIN_STARVE  = 1;
  localparam int MAX_STARVE  = 15;
  localparam int STARVE_W    = 4;

endpackage

// File: rtl/mem_arbiter_resp_pipe.sv
// ----------------------------------------------------------------------------
// RespPipe
//   Owner-tag shift register of depth DEPTH (the memory read latency).
//   A tag pushed in the grant cycle appears on tail_tag exactly DEPTH cycles
//   later, which is the cycle the memory presents the matching read data.
// Ports:
//   clk      in   clock
//   rst      in   asynchronous active-high reset, clears every stage to NONE
//   push_tag in   owner of the access issued this cycle (NONE for writes/idle)
//   tail_tag out  owner of the read data returning this cycle
// ----------------------------------------------------------------------------
module RespPipe
  import MemArbType::*;
#(
  parameter int DEPTH = 1
) (
  input  logic   clk,
  input  logic   rst,
  input  owner_t push_tag,
  output owner_t tail_tag
);

  owner_t pipe_q [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    owner_t stage_d;

    always_comb begin
      if (gi == 0) stage_d = push_tag;
      else         stage_d = pipe_q[(gi == 0) ? 0 : gi - 1];
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) pipe_q[gi] <= NONE;
      else     pipe_q[gi] <= stage_d;
    end
  end

  assign tail_tag = pipe_q[DEPTH-1];

endmodule

// File: rtl/mem_arbiter.sv
// ----------------------------------------------------------------------------
// mem_arbiter
//   Shares one single-port memory between instruction fetch (IF) and the MEM
//   stage (D). Data wins by default; after STARVE_LIMIT consecutive denied
//   fetch cycles, a pending fetch is forced through. A granted write inserts a
//   one-cycle TURN bubble. Read data is steered back to its owner using a tag
//   pipe whose depth equals the memory read latency.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   if_req/if_addr           fetch read request (held until if_gnt)
//   if_gnt                   fetch accepted this cycle (combinational)
//   if_rvalid/if_rdata       fetch read data return
//   d_req/d_we/d_addr/d_wdata data request (held until d_gnt)
//   d_gnt                    data accepted this cycle (combinational)
//   d_rvalid/d_rdata         data read data return
//   mem_en/mem_we/mem_addr/mem_wdata  memory command (combinational)
//   mem_rdata                memory read data, MEM_LATENCY cycles after issue
// ----------------------------------------------------------------------------
module mem_arbiter
  import MemArbType::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

  arb_state_t          state_q, state_d;
  logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;

  logic   can_grant;
  logic   fetch_forced;
  owner_t push_tag;
  owner_t tail_tag;

  // Arbitration and memory command. rst gates grants so every output reads
  // zero for the whole time reset is held, even if requests stay high.
  always_comb begin
    can_grant    = (state_q != TURN) && !rst;
    fetch_forced = (starve_cnt_q == LIMIT) && if_req;

    if_gnt = can_grant && (fetch_forced || (if_req && !d_req));
    d_gnt  = can_grant && !fetch_forced && d_req;

    mem_en    = if_gnt || d_gnt;
    mem_we    = d_gnt && d_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (d_gnt) begin
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (if_gnt) begin
      mem_addr = if_addr;
    end

    push_tag = NONE;
    if (if_gnt)              push_tag = IF;
    else if (d_gnt && !d_we) push_tag = D;
  end

  // Next state and starvation counter.
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;

    case (state_q)
      IDLE, ISSUE: begin
        if (d_gnt && d_we)          state_d = TURN;
        else if (if_gnt || d_gnt)   state_d = ISSUE;
        else                        state_d = IDLE;
      end
      TURN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Denied fetch cycles (including TURN bubbles) count towards starvation.
    if (if_gnt)                           starve_cnt_d = '0;
    else if (if_req && starve_cnt_q < LIMIT) starve_cnt_d = starve_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  RespPipe #(
    .DEPTH(MEM_LATENCY)
  ) u_resp_pipe (
    .clk     (clk),
    .rst     (rst),
    .push_tag(push_tag),
    .tail_tag(tail_tag)
  );

  always_comb begin
    if_rvalid = (tail_tag == IF);
    d_rvalid  = (tail_tag == D);
    if_rdata  = if_rvalid ? mem_rdata : '0;
    d_rdata   = d_rvalid  ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_arbiter
//   Two arbiters share one stimulus stream: dut1 (MEM_LATENCY=1) and dut3
//   (MEM_LATENCY=3), both STARVE_LIMIT=4. Each has its own behavioural memory
//   whose unwritten words read as 0x1000_0000 | addr[9:0].
// ----------------------------------------------------------------------------
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;

  // dut1 signals
  logic        g1_if_gnt, g1_if_rvalid, g1_d_gnt, g1_d_rvalid;
  logic        g1_mem_en, g1_mem_we;
  logic [31:0] g1_if_rdata, g1_d_rdata, g1_mem_addr, g1_mem_wdata, g1_mem_rdata;
  // dut3 signals
  logic        g3_if_gnt, g3_if_rvalid, g3_d_gnt, g3_d_rvalid;
  logic        g3_mem_en, g3_mem_we;
  logic [31:0] g3_if_rdata, g3_d_rdata, g3_mem_addr, g3_mem_wdata, g3_mem_rdata;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1), .STARVE_LIMIT(4)) dut1 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(g1_if_gnt),
    .if_rvalid(g1_if_rvalid), .if_rdata(g1_if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(g1_d_gnt), .d_rvalid(g1_d_rvalid), .d_rdata(g1_d_rdata),
    .mem_en(g1_mem_en), .mem_we(g1_mem_we), .mem_addr(g1_mem_addr),
    .mem_wdata(g1_mem_wdata), .mem_rdata(g1_mem_rdata)
  );

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(3), .STARVE_LIMIT(4)) dut3 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(g3_if_gnt),
    .if_rvalid(g3_if_rvalid), .if_rdata(g3_if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(g3_d_gnt), .d_rvalid(g3_d_rvalid), .d_rdata(g3_d_rdata),
    .mem_en(g3_mem_en), .mem_we(g3_mem_we), .mem_addr(g3_mem_addr),
    .mem_wdata(g3_mem_wdata), .mem_rdata(g3_mem_rdata)
  );

  // ---------------- behavioural memories ----------------
  function automatic logic [31:0] dflt(input logic [31:0] a);
    return 32'h1000_0000 | (a & 32'h0000_03FC);
  endfunction

  logic [31:0] m1_mem [256];
  logic        m1_wv  [256];
  logic [31:0] m1_val, m1_rd;
  logic [31:0] m3_mem [256];
  logic        m3_wv  [256];
  logic [31:0] m3_val, m3_rd_a, m3_rd_b, m3_rd_c;

  assign m1_val = m1_wv[g1_mem_addr[9:2]] ? m1_mem[g1_mem_addr[9:2]] : dflt(g1_mem_addr);
  assign m3_val = m3_wv[g3_mem_addr[9:2]] ? m3_mem[g3_mem_addr[9:2]] : dflt(g3_mem_addr);
  assign g1_mem_rdata = m1_rd;
  assign g3_mem_rdata = m3_rd_c;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) m1_wv[i] <= 1'b0;
    end else if (g1_mem_en && g1_mem_we) begin
      m1_mem[g1_mem_addr[9:2]] <= g1_mem_wdata;
      m1_wv[g1_mem_addr[9:2]]  <= 1'b1;
    end
    m1_rd <= m1_val;
  end

  always @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < 256; j++) m3_wv[j] <= 1'b0;
    end else if (g3_mem_en && g3_mem_we) begin
      m3_mem[g3_mem_addr[9:2]] <= g3_mem_wdata;
      m3_wv[g3_mem_addr[9:2]]  <= 1'b1;
    end
    m3_rd_a <= m3_val;
    m3_rd_b <= m3_rd_a;
    m3_rd_c <= m3_rd_b;
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        e_if_gnt;
    logic        e_d_gnt;
    logic        e_en;
    logic        e_we;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic        e_if_rv;
    logic [31:0] e_if_rd;
    logic        e_d_rv;
    logic [31:0] e_d_rd;
    logic [3:0]  e_cnt;
  } vec_t;

  function automatic vec_t mk(
    input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
    input logic [31:0] da, input logic [31:0] dwd,
    input logic eig, input logic edg, input logic een, input logic ewe,
    input logic [31:0] ea, input logic [31:0] ewd,
    input logic eirv, input logic [31:0] eird, input logic edrv, input logic [31:0] edrd,
    input logic [3:0] ecnt);
    vec_t v;
    v.if_req = ir;  v.if_addr = ia;  v.d_req = dr;  v.d_we = dw;
    v.d_addr = da;  v.d_wdata = dwd;
    v.e_if_gnt = eig; v.e_d_gnt = edg; v.e_en = een; v.e_we = ewe;
    v.e_addr = ea;  v.e_wdata = ewd;
    v.e_if_rv = eirv; v.e_if_rd = eird; v.e_d_rv = edrv; v.e_d_rd = edrd;
    v.e_cnt = ecnt;
    return v;
  endfunction

  vec_t vecs [22];

  task automatic drive(input logic ir, input logic [31:0] ia, input logic dr,
                       input logic dw, input logic [31:0] da, input logic [31:0] dwd);
    if_req = ir; if_addr = ia; d_req = dr; d_we = dw; d_addr = da; d_wdata = dwd;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " if_gnt"},    {63'd0, g1_if_gnt},    64'd0);
    chk({tag, " d_gnt"},     {63'd0, g1_d_gnt},     64'd0);
    chk({tag, " mem_en"},    {63'd0, g1_mem_en},    64'd0);
    chk({tag, " mem_we"},    {63'd0, g1_mem_we},    64'd0);
    chk({tag, " mem_addr"},  {32'd0, g1_mem_addr},  64'd0);
    chk({tag, " mem_wdata"}, {32'd0, g1_mem_wdata}, 64'd0);
    chk({tag, " if_rvalid"}, {63'd0, g1_if_rvalid}, 64'd0);
    chk({tag, " if_rdata"},  {32'd0, g1_if_rdata},  64'd0);
    chk({tag, " d_rvalid"},  {63'd0, g1_d_rvalid},  64'd0);
    chk({tag, " d_rdata"},   {32'd0, g1_d_rdata},   64'd0);
    chk({tag, " dut3 if_rvalid"}, {63'd0, g3_if_rvalid}, 64'd0);
    chk({tag, " dut3 d_rvalid"},  {63'd0, g3_d_rvalid},  64'd0);
    chk({tag, " dut3 mem_en"},    {63'd0, g3_mem_en},    64'd0);
  endtask

  // Latency-3 alternating sequence expectations (per cycle c0..c7).
  logic        l3_ir [8] = '{1, 0, 1, 0, 0, 0, 0, 0};
  logic        l3_dr [8] = '{0, 1, 0, 1, 0, 0, 0, 0};
  logic [31:0] l3_ad [8] = '{32'h10, 32'h14, 32'h18, 32'h1C, 0, 0, 0, 0};
  logic        l3_eir[8] = '{0, 0, 0, 1, 0, 1, 0, 0};
  logic        l3_edr[8] = '{0, 0, 0, 0, 1, 0, 1, 0};
  logic [31:0] l3_erd[8] = '{0, 0, 0, 32'h1000_0010, 32'h1000_0014,
                             32'h1000_0018, 32'h1000_001C, 0};

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //        ir ia     dr dw da      dwd           ig dg en we addr   wdata        irv ird           drv drd           cnt
    vecs[0]  = mk(1, 32'h0,  0, 0, 32'h0,   32'h0,        1, 0, 1, 0, 32'h0,   32'h0,        0, 32'h0,         0, 32'h0,         4'd0);
    vecs[1]  = mk(1, 32'h4,  0, 0, 32'h0,   32'h0,        1, 0, 1, 0, 32'h4,   32'h0,        1, 32'h1000_0000, 0, 32'h0,         4'd0);
    vecs[2]  = mk(1, 32'h8,  0, 0, 32'h0,   32'h0,        1, 0, 1, 0, 32'h8,   32'h0,        1, 32'h1000_0004, 0, 32'h0,         4'd0);
    vecs[3]  = mk(0, 32'h0,  0, 0, 32'h0,   32'h0,        0, 0, 0, 0, 32'h0,   32'h0,        1, 32'h1000_0008, 0, 32'h0,         4'd0);
    vecs[4]  = mk(0, 32'h0,  0, 0, 32'h0,   32'h0,        0, 0, 0, 0, 32'h0,   32'h0,        0, 32'h0,         0, 32'h0,         4'd0);
    vecs[5]  = mk(1, 32'h40, 1, 0, 32'h20,  32'h0,        0, 1, 1, 0, 32'h20,  32'h0,        0, 32'h0,         0, 32'h0,         4'd0);
    vecs[6]  = mk(1, 32'h40, 1, 0, 32'h20,  32'h0,        0, 1, 1, 0, 32'h20,  32'h0,        0, 32'h0,         1, 32'h1000_0020, 4'd1);
    vecs[7]  = mk(1, 32'h40, 1, 0, 32'h20,  32'h0,        0, 1, 1, 0, 32'h20,  32'h0,        0, 32'h0,         1, 32'h1000_0020, 4'd2);
    vecs[8]  = mk(1, 32'h40, 1, 0, 32'h20,  32'h0,        0, 1, 1, 0, 32'h20,  32'h0,        0, 32'h0,         1, 32'h1000_0020, 4'd3);
    vecs[9]  = mk(1, 32'h40, 1, 0, 32'h20,  32'h0,        1, 0, 1, 0, 32'h40,  32'h0,        0, 32'h0,         1, 32'h1000_0020, 4'd4);
    vecs[10] = mk(1, 32'h40, 1, 0, 32'h20,  32'h0,        0, 1, 1, 0, 32'h20,  32'h0,        1, 32'h1000_0040, 0, 32'h0,         4'd0);
    vecs[11] = mk(1, 32'h40, 1, 0, 32'h20,  32'h0,        0, 1, 1, 0, 32'h20,  32'h0,        0, 32'h0,         1, 32'h1000_0020, 4'd1);
    vecs[12] = mk(1, 32'h40, 1, 0, 32'h20,  32'h0,        0, 1, 1, 0, 32'h20,  32'h0,        0, 32'h0,         1, 32'h1000_0020, 4'd2);
    vecs[13] = mk(1, 32'h40, 1, 0, 32'h20,  32'h0,        0, 1, 1, 0, 32'h20,  32'h0,        0, 32'h0,         1, 32'h1000_0020, 4'd3);
    vecs[14] = mk(1, 32'h40, 1, 0, 32'h20,  32'h0,        1, 0, 1, 0, 32'h40,  32'h0,        0, 32'h0,         1, 32'h1000_0020, 4'd4);
    vecs[15] = mk(0, 32'h0,  0, 0, 32'h0,   32'h0,        0, 0, 0, 0, 32'h0,   32'h0,        1, 32'h1000_0040, 0, 32'h0,         4'd0);
    vecs[16] = mk(0, 32'h0,  0, 0, 32'h0,   32'h0,        0, 0, 0, 0, 32'h0,   32'h0,        0, 32'h0,         0, 32'h0,         4'd0);
    vecs[17] = mk(0, 32'h0,  1, 1, 32'h100, 32'hDEADBEEF, 0, 1, 1, 1, 32'h100, 32'hDEADBEEF, 0, 32'h0,         0, 32'h0,         4'd0);
    vecs[18] = mk(0, 32'h0,  1, 0, 32'h100, 32'h0,        0, 0, 0, 0, 32'h0,   32'h0,        0, 32'h0,         0, 32'h0,         4'd0);
    vecs[19] = mk(0, 32'h0,  1, 0, 32'h100, 32'h0,        0, 1, 1, 0, 32'h100, 32'h0,        0, 32'h0,         0, 32'h0,         4'd0);
    vecs[20] = mk(0, 32'h0,  0, 0, 32'h0,   32'h0,        0, 0, 0, 0, 32'h0,   32'h0,        0, 32'h0,         1, 32'hDEADBEEF,  4'd0);
    vecs[21] = mk(0, 32'h0,  0, 0, 32'h0,   32'h0,        0, 0, 0, 0, 32'h0,   32'h0,        0, 32'h0,         0, 32'h0,         4'd0);

    // ---- reset state ----
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk_all_zero("reset");
    chk("reset state", {62'd0, dut1.state_q}, {62'd0, MemArbType::IDLE});
    chk("reset cnt", {60'd0, dut1.starve_cnt_q}, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // ---- table-driven vectors on dut1 ----
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      drive(vecs[i].if_req, vecs[i].if_addr, vecs[i].d_req, vecs[i].d_we,
            vecs[i].d_addr, vecs[i].d_wdata);
      #1;
      chk($sformatf("v%0d if_gnt", i),    {63'd0, g1_if_gnt},    {63'd0, vecs[i].e_if_gnt});
      chk($sformatf("v%0d d_gnt", i),     {63'd0, g1_d_gnt},     {63'd0, vecs[i].e_d_gnt});
      chk($sformatf("v%0d mem_en", i),    {63'd0, g1_mem_en},    {63'd0, vecs[i].e_en});
      chk($sformatf("v%0d mem_we", i),    {63'd0, g1_mem_we},    {63'd0, vecs[i].e_we});
      chk($sformatf("v%0d mem_addr", i),  {32'd0, g1_mem_addr},  {32'd0, vecs[i].e_addr});
      chk($sformatf("v%0d mem_wdata", i), {32'd0, g1_mem_wdata}, {32'd0, vecs[i].e_wdata});
      chk($sformatf("v%0d if_rvalid", i), {63'd0, g1_if_rvalid}, {63'd0, vecs[i].e_if_rv});
      chk($sformatf("v%0d if_rdata", i),  {32'd0, g1_if_rdata},  {32'd0, vecs[i].e_if_rd});
      chk($sformatf("v%0d d_rvalid", i),  {63'd0, g1_d_rvalid},  {63'd0, vecs[i].e_d_rv});
      chk($sformatf("v%0d d_rdata", i),   {32'd0, g1_d_rdata},   {32'd0, vecs[i].e_d_rd});
      chk($sformatf("v%0d starve_cnt", i), {60'd0, dut1.starve_cnt_q}, {60'd0, vecs[i].e_cnt});
      $display("vec %0d: if_gnt=%b d_gnt=%b mem_en=%b mem_we=%b addr=%h if_rv=%b d_rv=%b",
               i, g1_if_gnt, g1_d_gnt, g1_mem_en, g1_mem_we, g1_mem_addr,
               g1_if_rvalid, g1_d_rvalid);
    end

    // Let dut3's outstanding read drain before the latency-3 sequence.
    repeat (4) @(negedge clk);

    // ---- MEM_LATENCY = 3, alternating IF/D reads on dut3 ----
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      drive(l3_ir[c], l3_ad[c], l3_dr[c], 0, l3_ad[c], 0);
      #1;
      chk($sformatf("l3 c%0d if_gnt", c),   {63'd0, g3_if_gnt},    {63'd0, l3_ir[c]});
      chk($sformatf("l3 c%0d d_gnt", c),    {63'd0, g3_d_gnt},     {63'd0, l3_dr[c]});
      chk($sformatf("l3 c%0d if_rvalid", c), {63'd0, g3_if_rvalid}, {63'd0, l3_eir[c]});
      chk($sformatf("l3 c%0d d_rvalid", c),  {63'd0, g3_d_rvalid},  {63'd0, l3_edr[c]});
      chk($sformatf("l3 c%0d if_rdata", c),  {32'd0, g3_if_rdata},
          {32'd0, (l3_eir[c] ? l3_erd[c] : 32'd0)});
      chk($sformatf("l3 c%0d d_rdata", c),   {32'd0, g3_d_rdata},
          {32'd0, (l3_edr[c] ? l3_erd[c] : 32'd0)});
      $display("lat3 %0d: if_gnt=%b d_gnt=%b if_rv=%b d_rv=%b rdata=%h/%h",
               c, g3_if_gnt, g3_d_gnt, g3_if_rvalid, g3_d_rvalid, g3_if_rdata, g3_d_rdata);
    end

    // ---- asynchronous reset with reads in flight ----
    @(negedge clk);
    drive(1, 32'h30, 0, 0, 0, 0);
    @(negedge clk);
    drive(0, 0, 1, 0, 32'h34, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("pre-rst d_rvalid", {63'd0, g1_d_rvalid}, 64'd1);
    chk("pre-rst d_rdata",  {32'd0, g1_d_rdata},  64'h1000_0034);
    #1;
    drive(1, 32'h50, 1, 0, 32'h54, 0);
    rst = 1'b1;
    #1;
    chk_all_zero("async rst");
    $display("async reset: outputs sampled 1ns after rst rise");
    repeat (2) @(posedge clk);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    #1;
    chk("post-rst state", {62'd0, dut1.state_q}, {62'd0, MemArbType::IDLE});
    chk("post-rst cnt",   {60'd0, dut1.starve_cnt_q}, 64'd0);
    chk("post-rst dut3 state", {62'd0, dut3.state_q}, {62'd0, MemArbType::IDLE});
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("post-rst c%0d if_rvalid", k),      {63'd0, g1_if_rvalid}, 64'd0);
      chk($sformatf("post-rst c%0d d_rvalid", k),       {63'd0, g1_d_rvalid},  64'd0);
      chk($sformatf("post-rst c%0d dut3 if_rvalid", k), {63'd0, g3_if_rvalid}, 64'd0);
      chk($sformatf("post-rst c%0d dut3 d_rvalid", k),  {63'd0, g3_d_rvalid},  64'd0);
      $display("post-reset %0d: rvalids %b%b %b%b", k,
               g1_if_rvalid, g1_d_rvalid, g3_if_rvalid, g3_d_rvalid);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single-port main memory between the instruction fetch stage and the MEM stage of the pipelined core. Each cycle it grants at most one requester, drives the memory port, and routes read data back to the owner after the memory's fixed read latency. Data accesses have priority; a starvation counter guarantees fetch progress. The block sits between the fetcher/MEM stage and the memory macro, replacing their separate private ports.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `MEM_LATENCY`, 1, memory read latency in cycles, legal range 1..4
- `STARVE_LIMIT`, 4, consecutive denied fetch cycles before fetch wins, legal range 1..15

Ports:
- `clk`  in  1  clock, all state updates on posedge
- `rst`  in  1  reset, asynchronous, active-high
- `if_req`  in  1  fetch read request, held until granted
- `if_addr`  in  ADDR_W  fetch address
- `if_gnt`  out  1  fetch request accepted this cycle
- `if_rvalid`  out  1  fetch read data valid
- `if_rdata`  out  DATA_W  fetch read data
- `d_req`  in  1  data request, held until granted
- `d_we`  in  1  1 = write, 0 = read
- `d_addr`  in  ADDR_W  data address
- `d_wdata`  in  DATA_W  write data
- `d_gnt`  out  1  data request accepted this cycle
- `d_rvalid`  out  1  data read data valid
- `d_rdata`  out  DATA_W  data read data
- `mem_en`  out  1  memory access strobe
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_rdata`  in  DATA_W  memory read data, valid MEM_LATENCY cycles after issue

## Operation
- FSM states: IDLE, ISSUE, TURN.
  - IDLE: no access issued last cycle. Any request moves to ISSUE.
  - ISSUE: an access was issued last cycle. Stays in ISSUE while requests continue; moves to IDLE when none are pending.
  - TURN: one-cycle write-to-read bubble, entered on the edge after any granted write. No grant is issued in TURN. Always exits to IDLE.
- Arbitration, evaluated in IDLE/ISSUE:
  - If `starve_cnt == STARVE_LIMIT` and `if_req`, grant fetch.
  - Otherwise, if `d_req`, grant data.
  - Otherwise, if `if_req`, grant fetch.
- Exactly one of `if_gnt`/`d_gnt` is high per grant cycle.
- The memory port is driven from the granted requester; `mem_we = d_we & d_gnt`.
- When nothing is granted: `mem_en = 0` and `mem_we = 0`.
- Starvation counter (4 bits):
  - Increments, saturating at STARVE_LIMIT, when `if_req & ~if_gnt`.
  - Clears on `if_gnt`.
  - Holds when `if_req = 0`.
- Response tracking:
  - An owner shift register of depth MEM_LATENCY tracks reads. Each entry is an owner tag: NONE, IF or D.
  - Writes push NONE.
  - When the tail is IF: `if_rvalid = 1` and `if_rdata = mem_rdata`. Same for D with `d_rvalid`/`d_rdata`.
  - When not valid, rdata outputs are 0.
- Responses return in issue order. Back-to-back reads are fully pipelined, one per cycle.

## Timing
- Grants are combinational from the current requests, the current state and `starve_cnt`, in the same cycle. `mem_*` outputs are also combinational and share that cycle.
- Read latency from grant cycle to rvalid cycle is exactly MEM_LATENCY cycles.
- A write is complete at its grant edge. The next grant is possible 2 cycles later, because of TURN.
- Simultaneous requests with `starve_cnt < STARVE_LIMIT`: data wins, and the fetch counter increments.
- Reset values, applied immediately on `rst`:
  - State IDLE.
  - `starve_cnt = 0`.
  - Owner pipe all NONE.
  - All outputs 0.
- Reset mid-operation: in-flight reads are dropped and no rvalid is produced after reset. Requesters reissue.
- Owner pipe, counter and FSM all advance every cycle; there is no stall input.

## Structure
- Package `MemArbType`:
  - `owner_t` enum {NONE, IF, D}.
  - `arb_state_t` enum {IDLE, ISSUE, TURN}.
  - Latency and starve range constants.
- Sub-module `RespPipe`: parameterised owner-tag shift register with async reset. Push tag in, tail tag out.
- Top level holds the FSM, the arbitration logic and the starvation counter.

## Test plan
- Only `if_req`, addresses 0x0, 0x4, 0x8 on consecutive cycles, `MEM_LATENCY = 1`:
  - `if_gnt` each cycle.
  - `if_rvalid` 1 cycle after each grant, with matching `mem_rdata`.
  - `d_rvalid` never asserted.
- `if_req` and `d_req` (read) held continuously, `STARVE_LIMIT = 4`:
  - `d_gnt` for 4 cycles, then `if_gnt` on the 5th.
  - `starve_cnt` returns to 0, then the pattern repeats.
- `d_req` write to 0x100 with data 0xDEADBEEF, then `d_req` read of 0x100 on the next cycle:
  - Write granted with `mem_we = 1`.
  - TURN cycle with no grant.
  - Read granted 2 cycles after the write.
  - `d_rdata = 0xDEADBEEF` after MEM_LATENCY cycles.
- `MEM_LATENCY = 3`, alternating IF/D reads:
  - rvalid outputs follow issue order, each exactly 3 cycles after its grant.
  - Tags are never swapped.
- Reset asserted asynchronously mid-cycle with 2 reads in flight:
  - All outputs go to 0 immediately.
  - No rvalid is produced after `rst` deasserts.
  - State is IDLE and the counter is 0.
